control_unit: RTL

Hardwired control sequencer for the Phase 3 CPU. Replaces the hand-driven testbench control vectors: it fetches each instruction, decodes IR[31:27], and steps the existing datapath through its T-state micro-sequences. The outputs drive the datapath control inputs of `CPU` one-for-one. It also provides run/halt control.

---
 rtl/control_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired T-state sequencer for the Phase 3 CPU datapath.
// Revision 1.0 - fetch/decode/execute sequencing with run/halt control.
`default_nettype none

module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        memRead,
  output logic        ramEnable,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        CONin,
  output logic        InPort_Out,
  output logic        OutPort_In,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic [15:0] R0_15in,
  output logic [15:0] R0_15out
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] last_state;
  logic [3:0] end_state;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign end_state = stop ? S_HALT : S_T0;

  // Final T-state of each instruction; nop and undefined opcodes end after fetch.
  always_comb begin
    last_state = S_T2;
    case (op)
      OP_LD, OP_ST:                                   last_state = S_T7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_state = S_T5;
      OP_BR:                                          last_state = S_T6;
      OP_IN, OP_OUT:                                  last_state = S_T3;
      default:                                        last_state = S_T2;
    endcase
  end

  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = S_T2;
      S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state == S_T2 && op == OP_HALT)
          next_state = S_HALT;
        else if (state == last_state)
          next_state = end_state;
        else
          next_state = state + 4'd1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      state <= S_RESET;
    else
      state <= next_state;
  end

  always_comb begin
    run        = (state != S_RESET) && (state != S_HALT);
    PCout      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    memRead    = 1'b0;
    ramEnable  = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    ADD        = 1'b0;
    SUB        = 1'b0;
    AND        = 1'b0;
    OR         = 1'b0;
    CONin      = 1'b0;
    InPort_Out = 1'b0;
    OutPort_In = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; end
      S_T1: begin memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          OP_BR:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_IN:  begin Gra = 1'b1; Rin = 1'b1; InPort_Out = 1'b1; end
          OP_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc  = 1'b1;
            Rout = 1'b1;
            Zin  = 1'b1;
            ADD  = (op == OP_ADD);
            SUB  = (op == OP_SUB);
            AND  = (op == OP_AND);
            OR   = (op == OP_OR);
          end
          OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_BR:  begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD: begin memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1; end
          // Store: data goes into MDR from Ra; memRead stays low so MDR takes the bus.
          OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          OP_BR: begin Zlowout = 1'b1; PCin = CON; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST: ramEnable = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
  assign HIout    = 1'b0;
  assign LOout    = 1'b0;
  assign Zhighout = 1'b0;
  assign R0_15in  = 16'h0000;
  assign R0_15out = 16'h0000;

endmodule

`default_nettype wire
